// File: rtl/i2s_receiver.sv
// I2S receiver: recovers left/right words from WS + serial data on the bit clock, publishes stereo frames.
// Latency: frame outputs update one edge after the right slot's last bit; no backpressure, frames are never stalled.
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  localparam int CNT_W = $clog2(2 * SLOT_WIDTH)
) (
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  word_select,
  input  logic                  sound_bit_in,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  frame_error,
  output logic                  locked,
  output logic [CNT_W-1:0]      bit_counter
);

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] RIGHT_BASE = CNT_W'(SLOT_WIDTH);

  state_t                r_state;
  logic                  r_ws_q;
  logic [CNT_W-1:0]      r_edge_cnt;
  logic [DATA_WIDTH-1:0] r_left_shift;
  logic [DATA_WIDTH-1:0] r_right_shift;
  logic [DATA_WIDTH-1:0] r_left_sample;
  logic [DATA_WIDTH-1:0] r_right_sample;
  logic                  r_sample_valid;
  logic                  r_frame_error;
  logic                  r_locked;
  logic [CNT_W-1:0]      r_bit_counter;

  logic                  w_ws_edge;
  logic                  w_slot_done;
  logic                  w_in_slot;
  logic                  w_error;
  logic                  w_capture;
  logic                  w_relock;
  logic [DATA_WIDTH-1:0] w_left_next;
  logic [DATA_WIDTH-1:0] w_right_next;

  assign w_ws_edge   = (word_select != r_ws_q);
  // The bit sampled at every locked edge has slot index r_edge_cnt, including the WS-edge edge.
  assign w_slot_done = (r_edge_cnt == LAST_IDX);
  assign w_in_slot   = (r_state == ST_LEFT) || (r_state == ST_RIGHT);
  // Either WS moved early (short slot) or it failed to move on the last bit (long slot / stuck WS).
  assign w_error     = w_in_slot && (w_ws_edge != w_slot_done);
  assign w_capture   = w_in_slot && !w_error && (int'(r_edge_cnt) < DATA_WIDTH);
  assign w_relock    = w_ws_edge && !word_select;

  assign w_left_next  = (w_capture && (r_state == ST_LEFT))
                      ? {r_left_shift[DATA_WIDTH-2:0], sound_bit_in} : r_left_shift;
  assign w_right_next = (w_capture && (r_state == ST_RIGHT))
                      ? {r_right_shift[DATA_WIDTH-2:0], sound_bit_in} : r_right_shift;

  always_ff @(posedge serial_clk) begin
    if (!reset) begin
      r_state        <= ST_SEEK;
      r_ws_q         <= word_select;
      r_edge_cnt     <= '0;
      r_left_shift   <= '0;
      r_right_shift  <= '0;
      r_left_sample  <= '0;
      r_right_sample <= '0;
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;
      r_locked       <= 1'b0;
      r_bit_counter  <= '0;
    end else begin
      r_ws_q         <= word_select;
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;
      r_left_shift   <= w_left_next;
      r_right_shift  <= w_right_next;
      case (r_state)
        ST_SEEK: begin
          r_locked      <= 1'b0;
          r_bit_counter <= '0;
          r_edge_cnt    <= '0;
          if (w_relock) begin
            r_state <= ST_LEFT;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (w_error) begin
            r_frame_error <= 1'b1;
            r_locked      <= 1'b0;
            r_bit_counter <= '0;
            r_edge_cnt    <= '0;
            r_state       <= w_relock ? ST_LEFT : ST_SEEK;
          end else begin
            r_locked      <= 1'b1;
            r_bit_counter <= ((r_state == ST_RIGHT) ? RIGHT_BASE : '0) + r_edge_cnt;
            if (w_ws_edge) begin
              r_edge_cnt <= '0;
              if (r_state == ST_LEFT) begin
                r_state <= ST_RIGHT;
              end else begin
                // Right slot closed at full length: both halves of this frame are complete.
                r_state        <= ST_LEFT;
                r_left_sample  <= r_left_shift;
                r_right_sample <= w_right_next;
                r_sample_valid <= 1'b1;
              end
            end else begin
              r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_SEEK;
        end
      endcase
    end
  end

  assign left_sample  = r_left_sample;
  assign right_sample = r_right_sample;
  assign sample_valid = r_sample_valid;
  assign frame_error  = r_frame_error;
  assign locked       = r_locked;
  assign bit_counter  = r_bit_counter;

endmodule
